// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: 16x oversampling UART receiver with 2-of-3 voting, runtime frame format and a one-entry valid/ready holding register
module uart_rx_ovs #(
    parameter int DLY        = 1,
    parameter int DATA_WIDTH = 9,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cfg_en_i,
    input  logic [DIV_WIDTH-1:0]  cfg_div_i,
    input  logic [3:0]            cfg_dbits_i,
    input  logic [1:0]            cfg_parity_i,
    input  logic                  cfg_stop_i,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_perr_o,
    output logic                  rx_ferr_o,
    output logic                  rx_vld_o,
    input  logic                  rx_rdy_i,
    output logic                  brk_o,
    output logic                  ovr_o,
    input  logic                  ovr_clr_i,
    output logic                  busy_o
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;
    localparam logic [3:0] DW4 = 4'(DATA_WIDTH);
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || DLY < 0) begin : g_param_err
        $error("uart_rx_ovs: illegal parameter value");
    end
    state_t                state, state_nxt;
    logic                  rx_m, rx_s;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [3:0]            s, bit_cnt, nbits;
    logic                  samp7, samp8, vote, tick, decide, wrap, start_det, done;
    logic                  par_en, par_exp, par_one, brk_cand, brk_first, brk, last_stop;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr, ferr, ovr_set;
    assign nbits     = (cfg_dbits_i < 4'd5) ? 4'd5 : (cfg_dbits_i > DW4) ? DW4 : cfg_dbits_i;
    assign tick      = div_cnt == cfg_div_i;
    assign decide    = tick && s == 4'd9;
    assign wrap      = tick && s == 4'd15;
    assign vote      = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
    assign start_det = state == IDLE && cfg_en_i && !rx_s;
    assign par_en    = ^cfg_parity_i;
    assign par_exp   = ^shreg ^ ~cfg_parity_i[1];
    assign last_stop = !cfg_stop_i || bit_cnt[0];
    assign done      = cfg_en_i && state == STOP && decide && last_stop;
    // Break: data and parity already seen as 0, first stop bit votes 0 now
    assign brk_first = shreg == '0 && !par_one && !vote;
    assign brk       = (bit_cnt == 4'd0) ? brk_first : brk_cand;
    assign ovr_set   = done && rx_vld_o && !rx_rdy_i;
    assign busy_o    = state != IDLE;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            state <= IDLE;
        end else begin
            rx_m  <= rx_i;
            rx_s  <= rx_m;
            state <= state_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start_det ? START : IDLE;
            START:   state_nxt = (decide && vote) ? IDLE : wrap ? DATA : START;
            DATA:    state_nxt = (wrap && bit_cnt == nbits - 4'd1) ? (par_en ? PARITY : STOP) : DATA;
            PARITY:  state_nxt = wrap ? STOP : PARITY;
            STOP:    state_nxt = done ? (brk ? BRKWAIT : IDLE) : STOP;
            BRKWAIT: state_nxt = rx_s ? IDLE : BRKWAIT;
            default: state_nxt = IDLE;
        endcase
        if (!cfg_en_i) state_nxt = IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt  <= '0;
            s        <= '0;
            bit_cnt  <= '0;
            samp7    <= 1'b1;
            samp8    <= 1'b1;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            par_one  <= 1'b0;
            brk_cand <= 1'b0;
        end else if (start_det) begin
            div_cnt  <= '0;
            s        <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            par_one  <= 1'b0;
            brk_cand <= 1'b0;
        end else if (state != IDLE) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) s <= s + 4'd1;
            if (tick && s == 4'd7) samp7 <= rx_s;
            if (tick && s == 4'd8) samp8 <= rx_s;
            // Bit index restarts whenever the frame moves to its next field
            if (wrap) bit_cnt <= (state_nxt != state) ? 4'd0 : bit_cnt + 4'd1;
            if (decide && state == DATA) shreg <= shreg | ({{(DATA_WIDTH-1){1'b0}}, vote} << bit_cnt);
            if (decide && state == PARITY) begin
                perr    <= vote != par_exp;
                par_one <= vote;
            end
            if (decide && state == STOP) begin
                ferr <= ferr | ~vote;
                if (bit_cnt == 4'd0) brk_cand <= brk_first;
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_data_o <= '0;
            rx_perr_o <= 1'b0;
            rx_ferr_o <= 1'b0;
            rx_vld_o  <= 1'b0;
            brk_o     <= 1'b0;
            ovr_o     <= 1'b0;
        end else begin
            brk_o <= done && brk;
            ovr_o <= ovr_set || (ovr_o && !ovr_clr_i);
            if (done && (!rx_vld_o || rx_rdy_i)) begin
                rx_data_o <= shreg;
                rx_perr_o <= perr;
                rx_ferr_o <= ferr | ~vote;
                rx_vld_o  <= 1'b1;
            end else if (!done && rx_rdy_i) begin
                rx_vld_o  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed self-checking bench for uart_rx_ovs
module tb_uart_rx_ovs;
    localparam int DW  = 9;
    localparam int BIT = 64;
    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b1, stop2 = 1'b0, rx = 1'b1, rdy = 1'b1, ovr_clr = 1'b0;
    logic [15:0]   div = 16'd3;
    logic [3:0]    dbits = 4'd8;
    logic [1:0]    par = 2'b00;
    logic [DW-1:0] data;
    logic          perr, ferr, vld, brk, ovr, busy;
    logic [DW-1:0] cap_data = '0;
    logic          cap_perr = 1'b0, cap_ferr = 1'b0;
    int            total = 0, bad = 0, n_xfer = 0, n_vld = 0, n_brk = 0, x0 = 0, v0 = 0, b0 = 0;
    always #5 clk = ~clk;
    uart_rx_ovs #(.DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_en_i(en), .cfg_div_i(div), .cfg_dbits_i(dbits),
        .cfg_parity_i(par), .cfg_stop_i(stop2), .rx_i(rx), .rx_data_o(data), .rx_perr_o(perr),
        .rx_ferr_o(ferr), .rx_vld_o(vld), .rx_rdy_i(rdy), .brk_o(brk), .ovr_o(ovr),
        .ovr_clr_i(ovr_clr), .busy_o(busy)
    );
    always @(posedge clk) begin
        if (vld) n_vld++;
        if (brk) n_brk++;
        if (vld && rdy) begin
            n_xfer++;
            cap_data = data;
            cap_perr = perr;
            cap_ferr = ferr;
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [15:0] f, input int len);
        for (int i = 0; i < len; i++) begin
            rx = f[i];
            clks(BIT);
        end
        rx = 1'b1;
    endtask
    initial begin
        clks(3);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_vld", 32'(vld), 32'h0);
        chk("rst_perr", 32'(perr), 32'h0);
        chk("rst_ferr", 32'(ferr), 32'h0);
        chk("rst_brk", 32'(brk), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        clks(5);
        x0 = n_xfer; v0 = n_vld;
        send({6'h3F, 1'b1, 8'hA5, 1'b0}, 10);
        clks(2 * BIT);
        chk("a5_xfer", 32'(n_xfer - x0), 32'd1);
        chk("a5_vld_cycles", 32'(n_vld - v0), 32'd1);
        chk("a5_data", 32'(cap_data), 32'h0A5);
        chk("a5_perr", 32'(cap_perr), 32'h0);
        chk("a5_ferr", 32'(cap_ferr), 32'h0);
        dbits = 4'd7; par = 2'b10; stop2 = 1'b1;
        x0 = n_xfer;
        send({5'h1F, 2'b11, 1'b0, 7'h55, 1'b0}, 11);
        clks(2 * BIT);
        chk("e72_good_xfer", 32'(n_xfer - x0), 32'd1);
        chk("e72_good_data", 32'(cap_data), 32'h055);
        chk("e72_good_perr", 32'(cap_perr), 32'h0);
        send({5'h1F, 2'b11, 1'b1, 7'h55, 1'b0}, 11);
        clks(2 * BIT);
        chk("e72_bad_xfer", 32'(n_xfer - x0), 32'd2);
        chk("e72_bad_data", 32'(cap_data), 32'h055);
        chk("e72_bad_perr", 32'(cap_perr), 32'h1);
        chk("e72_bad_ferr", 32'(cap_ferr), 32'h0);
        dbits = 4'd9; par = 2'b01; stop2 = 1'b0;
        send({4'hF, 1'b1, 1'b0, 9'h1FF, 1'b0}, 12);
        clks(2 * BIT);
        chk("o91_data", 32'(cap_data), 32'h1FF);
        chk("o91_perr", 32'(cap_perr), 32'h0);
        dbits = 4'd5; par = 2'b00;
        send({9'h1FF, 1'b1, 5'h13, 1'b0}, 7);
        clks(2 * BIT);
        chk("n51_data", 32'(cap_data), 32'h013);
        chk("n51_ferr", 32'(cap_ferr), 32'h0);
        dbits = 4'd8;
        x0 = n_xfer; b0 = n_brk;
        send({6'h3F, 1'b0, 8'h3C, 1'b0}, 10);
        clks(2 * BIT);
        chk("fe_xfer", 32'(n_xfer - x0), 32'd1);
        chk("fe_data", 32'(cap_data), 32'h03C);
        chk("fe_ferr", 32'(cap_ferr), 32'h1);
        chk("fe_no_brk", 32'(n_brk - b0), 32'd0);
        x0 = n_xfer;
        rx = 1'b0;
        clks(15 * BIT);
        chk("brk_busy", 32'(busy), 32'h1);
        chk("brk_pulse", 32'(n_brk - b0), 32'd1);
        chk("brk_xfer", 32'(n_xfer - x0), 32'd1);
        chk("brk_data", 32'(cap_data), 32'h0);
        chk("brk_ferr", 32'(cap_ferr), 32'h1);
        clks(5 * BIT);
        chk("brk_busy_held", 32'(busy), 32'h1);
        rx = 1'b1;
        clks(5);
        chk("brk_busy_rel", 32'(busy), 32'h0);
        chk("brk_once", 32'(n_brk - b0), 32'd1);
        rdy = 1'b0;
        x0 = n_xfer;
        send({6'h3F, 1'b1, 8'h11, 1'b0}, 10);
        clks(BIT);
        send({6'h3F, 1'b1, 8'h22, 1'b0}, 10);
        clks(2 * BIT);
        chk("ovr_vld", 32'(vld), 32'h1);
        chk("ovr_held", 32'(data), 32'h011);
        chk("ovr_flag", 32'(ovr), 32'h1);
        chk("ovr_noxfer", 32'(n_xfer - x0), 32'd0);
        rdy = 1'b1;
        clks(2);
        chk("ovr_acc_xfer", 32'(n_xfer - x0), 32'd1);
        chk("ovr_acc_data", 32'(cap_data), 32'h011);
        chk("ovr_acc_vld", 32'(vld), 32'h0);
        chk("ovr_sticky", 32'(ovr), 32'h1);
        ovr_clr = 1'b1;
        clks(1);
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(ovr), 32'h0);
        x0 = n_xfer;
        rx = 1'b0;
        clks(3);
        chk("glitch_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        clks(BIT);
        chk("glitch_idle", 32'(busy), 32'h0);
        chk("glitch_vld", 32'(vld), 32'h0);
        chk("glitch_noxfer", 32'(n_xfer - x0), 32'd0);
        rdy = 1'b0;
        send({6'h3F, 1'b1, 8'h5A, 1'b0}, 10);
        clks(BIT);
        chk("pre_rst_vld", 32'(vld), 32'h1);
        chk("pre_rst_data", 32'(data), 32'h05A);
        rx = 1'b0;
        clks(4 * BIT);
        chk("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(vld), 32'h0);
        chk("arst_data", 32'(data), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_ferr", 32'(ferr), 32'h0);
        chk("arst_perr", 32'(perr), 32'h0);
        rx = 1'b1;
        clks(2);
        rst_n = 1'b1;
        v0 = n_vld;
        clks(12 * BIT);
        chk("post_rst_vld", 32'(n_vld - v0), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
